// File: rtl/div_seq.sv
// Sequencer for the iterative divider: zero check, operand latch, init pulse,
// run-length count with stall, and HI/LO capture with direct mthi/mtlo writes.
module div_seq #(
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned WIDTH      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic [WIDTH-1:0] divHi,
   input  logic [WIDTH-1:0] divLo,
   input  logic             mtHi,
   input  logic             mtLo,
   input  logic [WIDTH-1:0] mtData,
   output logic [WIDTH-1:0] opA,
   output logic [WIDTH-1:0] opB,
   output logic             divCtrl,
   output logic             busy,
   output logic             done,
   output logic             divZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StCapture} state_e;

   state_e           r_state;
   logic [5:0]       r_cnt;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_div_ctrl;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_div_ctrl <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         case (r_state)
            StIdle: begin
               if (mtHi) r_hi <= mtData;
               if (mtLo) r_lo <= mtData;
               if (start) begin
                  if (srcB == '0) begin
                     r_div_zero <= 1'b1;
                  end else begin
                     r_op_a     <= srcA;
                     r_op_b     <= srcB;
                     r_div_ctrl <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= StLoad;
                  end
               end
            end
            StLoad: begin
               r_cnt      <= '0;
               r_div_ctrl <= 1'b0;
               r_state    <= StRun;
            end
            StRun: begin
               // Counter holds at its last value; the exit edge only changes state.
               if (r_cnt == 6'(DIV_CYCLES - 1)) r_state <= StCapture;
               else r_cnt <= r_cnt + 6'd1;
            end
            StCapture: begin
               r_hi    <= divHi;
               r_lo    <= divLo;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign opA     = r_op_a;
   assign opB     = r_op_b;
   assign divCtrl = r_div_ctrl;
   assign busy    = r_busy;
   assign done    = r_done;
   assign divZero = r_div_zero;
   assign hi      = r_hi;
   assign lo      = r_lo;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: vector table, hand-written corner sequences and random ops
// against a plain-arithmetic model, with a behavioural 32-step divider attached.
module tb_div_seq;

   localparam int unsigned W  = 32;
   localparam int unsigned DC = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] srcA, srcB, divHi, divLo, mtData;
   logic         mtHi, mtLo;
   logic [W-1:0] opA, opB, hi, lo;
   logic         divCtrl, busy, done, divZero;

   int n_checks = 0;
   int n_errors = 0;
   int g_ctrl   = 0;

   div_seq #(.DIV_CYCLES(DC), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .srcA(srcA), .srcB(srcB),
      .divHi(divHi), .divLo(divLo), .mtHi(mtHi), .mtLo(mtLo), .mtData(mtData),
      .opA(opA), .opB(opB), .divCtrl(divCtrl), .busy(busy), .done(done),
      .divZero(divZero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Divider model: samples operands on its init edge, shows junk while iterating,
   // and presents the result only after DC further edges.
   logic [W-1:0] m_a, m_b;
   int           m_n = 0;
   always @(posedge clk) begin
      if (divCtrl) begin
         m_a   <= opA;
         m_b   <= opB;
         m_n   <= DC;
         divHi <= $urandom;
         divLo <= $urandom;
      end else if (m_n > 0) begin
         m_n <= m_n - 1;
         if (m_n == 1) begin
            divHi <= (m_b != 0) ? m_a % m_b : '0;
            divLo <= (m_b != 0) ? m_a / m_b : '0;
         end
      end
   end

   always @(negedge clk) if (divCtrl) g_ctrl++;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one start and watch 40 cycles; cycle 1 is the cycle after the accepting edge.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n_ctrl, output int n_busy, output int done_cyc,
                        output int n_zero);
      n_ctrl = 0; n_busy = 0; done_cyc = 0; n_zero = 0;
      start = 1'b1; srcA = a; srcB = b;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (divCtrl) n_ctrl++;
         if (busy) n_busy++;
         if (done && done_cyc == 0) done_cyc = c;
         if (divZero) n_zero++;
         @(negedge clk);
      end
   endtask

   task automatic wait_done(input int max, output int cyc);
      cyc = 0;
      for (int c = 1; c <= max; c++) begin
         if (done) begin
            cyc = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_op(input string tag, input logic zero, input int n_ctrl,
                           input int n_busy, input int done_cyc, input int n_zero);
      chk({tag, "_divctrl_cycles"}, n_ctrl, zero ? 0 : 1);
      chk({tag, "_busy_cycles"}, n_busy, zero ? 0 : DC + 2);
      chk({tag, "_done_cycle"}, done_cyc, zero ? 0 : DC + 3);
      chk({tag, "_divzero_cycles"}, n_zero, zero ? 1 : 0);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
      logic         zero;
   } vec_t;

   vec_t vecs[6];
   int   nc, nb, dcy, nz, cyc, ctrl0;
   logic [W-1:0] m_hi, m_lo, a, b, hi_before;

   initial begin
      vecs[0] = '{32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
      vecs[1] = '{32'd1000, 32'd10, 32'd0, 32'd100, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0};
      vecs[3] = '{32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1};
      vecs[4] = '{32'd7, 32'd9, 32'd7, 32'd0, 1'b0};
      vecs[5] = '{32'd0, 32'd3, 32'd0, 32'd0, 1'b0};

      reset = 1'b0; start = 1'b0; srcA = '0; srcB = '0; mtHi = 1'b0; mtLo = 1'b0;
      mtData = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_divctrl", divCtrl, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_opa", opA, 0);
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, nc, nb, dcy, nz);
         check_op($sformatf("vec%0d", i), vecs[i].zero, nc, nb, dcy, nz);
         chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
         chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
         if (!vecs[i].zero) chk($sformatf("vec%0d_opa", i), opA, vecs[i].a);
      end

      // Preload HI/LO, then divide by zero leaves them alone.
      mtHi = 1'b1; mtData = 32'hDEAD_BEEF; @(negedge clk);
      mtHi = 1'b0; mtLo = 1'b1; mtData = 32'h1234_5678; @(negedge clk);
      mtLo = 1'b0;
      do_op(32'd5, 32'd0, nc, nb, dcy, nz);
      check_op("t2", 1'b1, nc, nb, dcy, nz);
      chk("t2_hi", hi, 32'hDEAD_BEEF);
      chk("t2_lo", lo, 32'h1234_5678);

      // Start and mthi during RUN are both ignored.
      start = 1'b1; srcA = 32'd1000; srcB = 32'd10; @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      hi_before = hi;
      start = 1'b1; srcA = 32'd9; srcB = 32'd3; mtHi = 1'b1; mtData = 32'h55;
      @(negedge clk);
      start = 1'b0; mtHi = 1'b0;
      chk("t3_opa_held", opA, 32'd1000);
      chk("t3_opb_held", opB, 32'd10);
      chk("t3_hi_mt_ignored", hi, hi_before);
      wait_done(40, cyc);
      chk("t3_done_seen", (cyc != 0), 1);
      chk("t3_hi", hi, 32'd0);
      chk("t3_lo", lo, 32'd100);
      repeat (3) @(negedge clk);
      chk("t3_idle_after", busy, 0);

      // Asynchronous reset at counter=10 (cycle 12 after the accepting edge).
      start = 1'b1; srcA = 32'd50; srcB = 32'd5; @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      chk("t4_busy_before_rst", busy, 1);
      #1 reset = 1'b0;
      #1;
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_opa", opA, 0);
      chk("t4_rst_opb", opB, 0);
      chk("t4_rst_hi", hi, 0);
      chk("t4_rst_lo", lo, 0);
      chk("t4_rst_pulses", {divCtrl, done, divZero}, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_op(32'hFFFF_FFFF, 32'd1, nc, nb, dcy, nz);
      check_op("t4", 1'b0, nc, nb, dcy, nz);
      chk("t4_hi", hi, 32'd0);
      chk("t4_lo", lo, 32'hFFFF_FFFF);

      // Back-to-back: new start in the cycle done is high.
      ctrl0 = g_ctrl;
      start = 1'b1; srcA = 32'd20; srcB = 32'd6; @(negedge clk);
      start = 1'b0;
      wait_done(40, cyc);
      chk("t5_first_done_cycle", cyc, DC + 3);
      chk("t5_hi1", hi, 32'd2);
      chk("t5_lo1", lo, 32'd3);
      start = 1'b1; srcA = 32'd81; srcB = 32'd9; @(negedge clk);
      start = 1'b0;
      chk("t5_second_accepted", busy, 1);
      wait_done(40, cyc);
      chk("t5_second_done_cycle", cyc, DC + 3);
      chk("t5_hi2", hi, 32'd0);
      chk("t5_lo2", lo, 32'd9);
      chk("t5_divctrl_pulses", g_ctrl - ctrl0, 2);

      // Idle mthi+mtlo together.
      @(negedge clk);
      mtHi = 1'b1; mtLo = 1'b1; mtData = 32'hA5A5_A5A5; @(negedge clk);
      mtHi = 1'b0; mtLo = 1'b0;
      chk("t6_hi", hi, 32'hA5A5_A5A5);
      chk("t6_lo", lo, 32'hA5A5_A5A5);
      chk("t6_busy", busy, 0);

      // Random ops against an arithmetic model of HI/LO.
      m_hi = hi; m_lo = lo;
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            mtHi = 1'($urandom); mtLo = 1'($urandom); mtData = $urandom;
            @(negedge clk);
            if (mtHi) m_hi = mtData;
            if (mtLo) m_lo = mtData;
            mtHi = 1'b0; mtLo = 1'b0;
         end
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = '0;
            1: b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         do_op(a, b, nc, nb, dcy, nz);
         if (b != 0) begin
            m_hi = a % b;
            m_lo = a / b;
         end
         check_op($sformatf("rnd%0d", i), (b == 0), nc, nb, dcy, nz);
         chk($sformatf("rnd%0d_hi", i), hi, m_hi);
         chk($sformatf("rnd%0d_lo", i), lo, m_lo);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequencer between the control unit and the iterative 32-step divider.
- Checks for divide-by-zero and latches the operands.
- Issues the single-cycle divider init pulse, counts the divider's fixed run length and stalls the control unit while it runs.
- Captures the divider's remainder/quotient into the architectural HI/LO registers, which also accept direct writes (mthi/mtlo).

Parameters:
DIV_CYCLES, 32, number of divider iteration cycles after its init cycle
WIDTH, 32, operand/result width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  div instruction issue, sampled only in IDLE
srcA  input  WIDTH  numerator from register file
srcB  input  WIDTH  denominator from register file
divHi  input  WIDTH  remainder from divider
divLo  input  WIDTH  quotient from divider
mtHi  input  1  write mtData into HI
mtLo  input  1  write mtData into LO
mtData  input  WIDTH  data for mtHi/mtLo
opA  output  WIDTH  latched numerator to divider
opB  output  WIDTH  latched denominator to divider
divCtrl  output  1  divider init pulse
busy  output  1  stall request to control unit
done  output  1  one-cycle completion pulse
divZero  output  1  one-cycle divide-by-zero exception pulse
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- All outputs registered. While reset=0: state=IDLE, counter=0, opA=opB=hi=lo=0, divCtrl=busy=done=divZero=0. Outputs are cleared asynchronously on reset assertion, not at the next clk edge.
- States: IDLE, LOAD, RUN, CAPTURE. Counter is 6 bits wide and counts 0..DIV_CYCLES-1 in RUN.
- IDLE, start=1, srcB!=0:
  - At edge T0: opA<=srcA, opB<=srcB, state<=LOAD.
  - In the LOAD cycle: divCtrl=1 and busy=1.
- IDLE, start=1, srcB==0:
  - divZero=1 for exactly one cycle after the edge.
  - State stays IDLE; hi, lo, opA, opB unchanged; busy stays 0.
- LOAD -> RUN at T1, counter<=0, divCtrl<=0. The divider samples opA/opB at T1.
- RUN: counter increments each edge. When counter==DIV_CYCLES-1, the next edge (T0+DIV_CYCLES+1) enters CAPTURE.
- CAPTURE -> IDLE at T0+DIV_CYCLES+2: hi<=divHi, lo<=divLo, done<=1 for one cycle, busy<=0.
- Cycle counts with defaults:
  - busy is high for exactly DIV_CYCLES+2 = 34 cycles.
  - done is asserted in the 35th cycle after T0.
- divCtrl is high for exactly one cycle per accepted start.
- start while busy=1 is ignored; operands are not re-latched. The control unit is required to hold the instruction via busy.
- start in the same cycle that done is high is accepted, since the state is IDLE.
- mtHi/mtLo:
  - Honoured only when busy=0; HI/LO update at the next edge.
  - Ignored while busy=1.
  - mtHi together with mtLo writes both registers.
  - mt with a same-cycle accepted start: the mt write takes effect, and the later capture overwrites it.
- Reset mid-operation (any state): immediate return to IDLE with all outputs cleared. The divider's internal state is irrelevant; the next accepted start re-initialises it.
- opA/opB are held stable from T0 until the next accepted start.
- No arithmetic beyond the zero check and the counter increment. Counter wrap is impossible because RUN exits at DIV_CYCLES-1.

Test Plan:
1. With a behavioural divider model: start, srcA=100, srcB=7 -> divCtrl high exactly 1 cycle; busy high 34 cycles; done pulse in cycle 35; hi=2, lo=14.
2. Preload via mtHi/mtLo: hi=0xDEADBEEF, lo=0x12345678; then start, srcA=5, srcB=0 -> divZero high 1 cycle; busy, divCtrl and done stay 0; hi/lo unchanged.
3. Accepted start 1000/10, then start 9/3 with mtHi=1, mtData=0x55 during RUN -> second start and mt ignored; opA stays 1000; final hi=0, lo=100.
4. Accepted start 50/5, then reset=0 at counter=10 -> all outputs 0 immediately. After release, start 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0 after 34 busy cycles.
5. Accepted start 20/6, then a new start 81/9 in the same cycle done is asserted -> second run accepted; after the first done: hi=2, lo=3; after the second done: hi=0, lo=9; divCtrl pulses exactly twice.
6. Idle: mtHi=1, mtLo=1, mtData=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5 after one edge; busy stays 0.
